fp_sqrt_iter: RTL and testbench

Parametrised IEEE-754 floating-point square root with a valid/ready handshake on both sides. It is the successor of the fixed single-precision square-root unit. Exponent and mantissa widths are generics, and it adds special-case handling, round-to-nearest-even and exception flags. Its core is a multi-cycle restoring digit-recurrence, one result bit per cycle, which trades area for latency and sits in the FP datapath beside the other arithmetic units.

---
 rtl/fp_sqrt_iter.sv | 167 ++++++++++++++++
 tb/tb_fp_sqrt_iter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_iter.sv
// rtl/fp_sqrt_iter.sv - iterative IEEE-754 square root, one root bit per cycle
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   valid_i  operand valid
//   ready_o  unit can accept an operand (IDLE only)
//   data_i   operand {sign, exp, man}
//   valid_o  result valid (DONE)
//   ready_i  downstream accepts result
//   data_o   result {sign, exp, man}
//   flags_o  {invalid, inexact}, qualified by valid_o
module fp_sqrt_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int DATAWIDTH = 1 + EXP_W + MAN_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DATAWIDTH-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DATAWIDTH-1:0] data_o,
    output logic [1:0]           flags_o
);

    // Q root bits: hidden one, MAN_W mantissa bits, one guard bit
    localparam int Q     = MAN_W + 2;
    localparam int CNT_W = $clog2(Q);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(2**(EXP_W-1) - 1);
    localparam logic [DATAWIDTH-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2*Q-1:0]   rad;
    logic [Q+2:0]     rem;
    logic [Q-1:0]     root;
    logic [EXP_W-1:0] res_exp;

    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);

    // Operand classification; denormals (exp field zero) are treated as zero
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [MAN_W-1:0] in_man;
    logic             exp_ones, exp_zero, is_nan, is_inf, is_special;
    logic [DATAWIDTH-1:0] spec_data;
    logic [1:0]       spec_flags;

    assign in_sign  = data_i[DATAWIDTH-1];
    assign in_exp   = data_i[DATAWIDTH-2:MAN_W];
    assign in_man   = data_i[MAN_W-1:0];
    assign exp_ones = &in_exp;
    assign exp_zero = ~|in_exp;
    assign is_nan   = exp_ones & (|in_man);
    assign is_inf   = exp_ones & ~(|in_man);
    assign is_special = exp_ones | exp_zero | in_sign;

    always_comb begin
        spec_data  = QNAN;
        spec_flags = 2'b10;
        if (is_nan) begin
            spec_data  = QNAN;
            spec_flags = 2'b10;
        end else if (exp_zero) begin
            spec_data  = {in_sign, {(DATAWIDTH-1){1'b0}}};
            spec_flags = 2'b00;
        end else if (in_sign) begin
            spec_data  = QNAN;
            spec_flags = 2'b10;
        end else if (is_inf) begin
            spec_data  = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flags = 2'b00;
        end
    end

    // The bias is odd, so an even biased exponent means an odd unbiased one
    logic                     e_odd;
    logic signed [EXP_W+1:0]  e_unb, e_adj, e_res;
    logic [Q-1:0]             sig_adj;

    assign e_odd   = ~in_exp[0];
    assign e_unb   = $signed({2'b00, in_exp}) - BIAS_S;
    assign e_adj   = e_unb - $signed({{(EXP_W+1){1'b0}}, e_odd});
    assign e_res   = (e_adj >>> 1) + BIAS_S;
    assign sig_adj = e_odd ? {1'b1, in_man, 1'b0} : {1'b0, 1'b1, in_man};

    // One restoring step: bring down two radicand bits, try subtracting 4*root+1
    logic [Q+2:0] rem_t, trial;
    logic         take;

    assign rem_t = {rem[Q:0], rad[2*Q-1:2*Q-2]};
    assign trial = {1'b0, root, 2'b01};
    assign take  = (rem_t >= trial);

    // Round to nearest even on guard/sticky; a carry out means the root became 2.0
    logic         guard, sticky, round_up;
    logic [MAN_W:0] man_sum;

    assign guard    = root[0];
    assign sticky   = |rem;
    assign round_up = guard & (sticky | root[1]);
    assign man_sum  = {1'b0, root[Q-2:1]} + {{MAN_W{1'b0}}, round_up};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rad     <= '0;
            rem     <= '0;
            root    <= '0;
            res_exp <= '0;
            data_o  <= '0;
            flags_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (is_special) begin
                            data_o  <= spec_data;
                            flags_o <= spec_flags;
                            state   <= DONE;
                        end else begin
                            rad     <= {sig_adj, {Q{1'b0}}};
                            rem     <= '0;
                            root    <= '0;
                            res_exp <= e_res[EXP_W-1:0];
                            cnt     <= CNT_W'(Q - 1);
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    rad  <= {rad[2*Q-3:0], 2'b00};
                    rem  <= take ? (rem_t - trial) : rem_t;
                    root <= {root[Q-2:0], take};
                    if (cnt == '0) begin
                        state <= ROUND;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ROUND: begin
                    data_o  <= {1'b0, res_exp + {{(EXP_W-1){1'b0}}, man_sum[MAN_W]},
                                man_sum[MAN_W-1:0]};
                    flags_o <= {1'b0, guard | sticky};
                    state   <= DONE;
                end
                default: begin
                    if (ready_i) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// tb/tb_fp_sqrt_iter.sv - scoreboard bench for fp_sqrt_iter (single and half precision)
module tb_fp_sqrt_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v32 = 1'b0, r32o, vo32, ri32 = 1'b1;
    logic [31:0] d32i = '0, do32;
    logic [1:0]  fl32;
    logic        v16 = 1'b0, r16o, vo16, ri16 = 1'b1;
    logic [15:0] d16i = '0, do16;
    logic [1:0]  fl16;

    fp_sqrt_iter #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst_n(rst_n), .valid_i(v32), .ready_o(r32o), .data_i(d32i),
        .valid_o(vo32), .ready_i(ri32), .data_o(do32), .flags_o(fl32)
    );

    fp_sqrt_iter #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst_n(rst_n), .valid_i(v16), .ready_o(r16o), .data_i(d16i),
        .valid_o(vo16), .ready_i(ri16), .data_o(do16), .flags_o(fl16)
    );

    typedef struct {
        logic [31:0] d;
        logic [1:0]  f;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic pv32 = 1'b0, pv16 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Monitors: compare whatever the DUT presents against the head of its queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (vo32) begin
                check("ready_in_done32", {31'b0, r32o}, 32'd0);
                if (q32.size() == 0) begin
                    fail_now("unexpected_result32");
                end else begin
                    if (!pv32) check("latency32", cyc - q32[0].acc + 1, q32[0].lat);
                    check("data32", do32, q32[0].d);
                    check("flags32", {30'b0, fl32}, {30'b0, q32[0].f});
                    if (ri32) void'(q32.pop_front());
                end
            end
            pv32 = vo32;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (vo16) begin
                check("ready_in_done16", {31'b0, r16o}, 32'd0);
                if (q16.size() == 0) begin
                    fail_now("unexpected_result16");
                end else begin
                    if (!pv16) check("latency16", cyc - q16[0].acc + 1, q16[0].lat);
                    check("data16", {16'b0, do16}, q16[0].d);
                    check("flags16", {30'b0, fl16}, {30'b0, q16[0].f});
                    if (ri16) void'(q16.pop_front());
                end
            end
            pv16 = vo16;
        end
    end

    // Drive an operand; the expectation is queued once ready_o guarantees acceptance
    task automatic issue(input int w, input logic [31:0] d, input logic [31:0] e,
                         input logic [1:0] f, input int lat);
        int n;
        exp_t x;
        n = 0;
        @(negedge clk);
        if (w == 0) begin v32 = 1'b1; d32i = d; end
        else begin v16 = 1'b1; d16i = d[15:0]; end
        while (((w == 0) ? r32o : r16o) !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            fail_now("accept_timeout");
        end else begin
            x.d = e; x.f = f; x.lat = lat; x.acc = cyc + 1;
            if (w == 0) q32.push_back(x);
            else q16.push_back(x);
        end
        @(posedge clk);
        #1;
        if (w == 0) v32 = 1'b0;
        else v16 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q32.size() != 0 || q16.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_now("drain_timeout");
    endtask

    initial begin
        #1;
        check("reset_ready", {31'b0, r32o}, 32'd1);
        check("reset_valid", {31'b0, vo32}, 32'd0);
        check("reset_data", do32, 32'd0);
        check("reset_flags", {30'b0, fl32}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        issue(0, 32'h40800000, 32'h40000000, 2'b00, 27);
        issue(0, 32'h3E800000, 32'h3F000000, 2'b00, 27);
        issue(0, 32'h40000000, 32'h3FB504F3, 2'b01, 27);
        issue(0, 32'h7F7FFFFF, 32'h5F7FFFFF, 2'b01, 27);
        issue(0, 32'h00400000, 32'h00000000, 2'b00, 1);
        issue(0, 32'h80000000, 32'h80000000, 2'b00, 1);
        issue(0, 32'h7F800000, 32'h7F800000, 2'b00, 1);
        issue(0, 32'hBF800000, 32'h7FC00000, 2'b10, 1);
        issue(0, 32'hFF800001, 32'h7FC00000, 2'b10, 1);
        issue(1, 32'h4400, 32'h4000, 2'b00, 14);
        issue(1, 32'h4000, 32'h3DA8, 2'b01, 14);
        issue(1, 32'hBC00, 32'h7E00, 2'b10, 1);
        drain();

        // Backpressure with a second operand waiting on the input
        ri32 = 1'b0;
        fork
            begin
                issue(0, 32'h40800000, 32'h40000000, 2'b00, 27);
                issue(0, 32'h3E800000, 32'h3F000000, 2'b00, 27);
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (vo32 !== 1'b1 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 100) fail_now("backpressure_valid_timeout");
                repeat (10) begin
                    @(negedge clk);
                    check("bp_valid_held", {31'b0, vo32}, 32'd1);
                    check("bp_ready_low", {31'b0, r32o}, 32'd0);
                end
                @(posedge clk);
                #1 ri32 = 1'b1;
            end
        join
        drain();

        // Reset in the middle of a computation
        issue(0, 32'h40000000, 32'h3FB504F3, 2'b01, 27);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_valid", {31'b0, vo32}, 32'd0);
        check("midreset_ready", {31'b0, r32o}, 32'd1);
        check("midreset_data", do32, 32'd0);
        check("midreset_flags", {30'b0, fl32}, 32'd0);
        q32.delete();
        pv32 = 1'b0;
        #20 rst_n = 1'b1;
        issue(0, 32'h3F800000, 32'h3F800000, 2'b00, 27);
        drain();
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
